// File: rtl/multicycle_core_hs.sv
// Multicycle accumulator core with an integrated control FSM and a req/ready memory port.
// Optional performance counters are enabled by defining MULTICYCLE_CORE_HS_PERF_EN.
module multicycle_core_hs #(
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-5:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [DATA_W-5:0] pc
`ifdef MULTICYCLE_CORE_HS_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_retired
`endif
);

  localparam int ADDR_W = DATA_W - 4;
  localparam int IMM_W  = DATA_W - 7;
  localparam int PAGE_W = ADDR_W - IMM_W;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_CTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_ANDI  = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] FN_MOVTO = 3'b000;
  localparam logic [2:0] FN_MOVFR = 3'b001;
  localparam logic [2:0] FN_ADD   = 3'b010;
  localparam logic [2:0] FN_SUB   = 3'b011;
  localparam logic [2:0] FN_AND   = 3'b100;
  localparam logic [2:0] FN_OR    = 3'b101;
  localparam logic [2:0] FN_NOT   = 3'b110;
  localparam logic [2:0] FN_NOP   = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_MEMWR,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] ir, mdr, a, b, alu_out, alu;
  logic [DATA_W-1:0] regs [8];
  // Only the page bits of the fetch PC are ever consumed (BRZ target), so only they are kept.
  logic [PAGE_W-1:0] old_page;

  logic [3:0]        op;
  logic [2:0]        rn, fn;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] adr;

  assign op  = ir[DATA_W-1 -: 4];
  assign rn  = ir[DATA_W-5 -: 3];
  assign imm = ir[IMM_W-1:0];
  assign adr = ir[ADDR_W-1:0];
  assign fn  = ir[2:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu = a;
    case (op)
      OP_ADDI: alu = a + {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      OP_ANDI: alu = a & {{(DATA_W-IMM_W){1'b0}}, imm};
      default: begin
        case (fn)
          FN_MOVTO: alu = a;
          FN_MOVFR: alu = b;
          FN_ADD:   alu = a + b;
          FN_SUB:   alu = a - b;
          FN_AND:   alu = a & b;
          FN_OR:    alu = a | b;
          FN_NOT:   alu = ~a;
          default:  alu = a;
        endcase
      end
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD:                     nxt = S_MEMRD;
          OP_STORE:                    nxt = S_MEMWR;
          OP_CTYPE, OP_ADDI, OP_ANDI:  nxt = S_EXEC;
          OP_HALT:                     nxt = S_HALT;
          default:                     nxt = S_FETCH;
        endcase
      end
      S_MEMRD:  if (mem_ready) nxt = S_WB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC:   nxt = (op == OP_CTYPE && fn == FN_NOP) ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= ADDR_W'(RESET_PC);
      ir       <= '0;
      old_page <= '0;
      mdr      <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is flops, not a RAM macro.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir       <= mem_rdata;
            old_page <= pc[ADDR_W-1:IMM_W];
            pc       <= pc + 1'b1;
          end
        end
        S_DECODE: begin
          a <= regs[0];
          b <= regs[rn];
          if (op == OP_JUMP) pc <= adr;
          if (op == OP_BRZ && regs[0] == '0) pc <= {old_page, imm};
        end
        S_MEMRD: if (mem_ready) mdr <= mem_rdata;
        S_EXEC:  alu_out <= alu;
        S_WB: begin
          if (op == OP_LOAD)                          regs[0]  <= mdr;
          else if (op == OP_CTYPE && fn == FN_MOVTO)  regs[rn] <= alu_out;
          else                                        regs[0]  <= alu_out;
        end
        default: ;
      endcase
    end
  end

  // Gating with reset makes the request drop immediately, even mid-handshake.
  always_comb begin
    mem_req   = !reset && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
    mem_we    = (state == S_MEMWR);
    mem_addr  = (state == S_MEMRD || state == S_MEMWR) ? adr : pc;
    mem_wdata = regs[0];
    halted    = (state == S_HALT);
  end

`ifdef MULTICYCLE_CORE_HS_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      if (state != S_HALT) perf_cycles <= perf_cycles + 32'd1;
      if (state != S_FETCH && nxt == S_FETCH) perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_core_hs.sv
// Scoreboard bench: an instruction-level reference model predicts every memory transaction of
// the 16-bit core; a monitor pops and compares each completed handshake and checks request hold.
module tb_multicycle_core_hs;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, mem_ready, halted;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] mem [0:4095];
  assign mem_rdata = mem[mem_addr];

  logic        req24, we24, halted24;
  logic        ready24 = 1'b1;
  logic [19:0] addr24, pc24;
  logic [23:0] wdata24, rdata24;
  assign rdata24 = (addr24 == 20'h00000) ? 24'h2FFFFF :
                   (addr24 == 20'hFFFFF) ? 24'hF00000 : 24'h000000;

`ifdef MULTICYCLE_CORE_HS_PERF_EN
  logic [31:0] perf_c16, perf_r16, perf_c24, perf_r24;
`endif

  multicycle_core_hs #(.DATA_W(16), .RESET_PC(0)) u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted), .pc(pc)
`ifdef MULTICYCLE_CORE_HS_PERF_EN
    , .perf_cycles(perf_c16), .perf_retired(perf_r16)
`endif
  );

  multicycle_core_hs #(.DATA_W(24), .RESET_PC(0)) u_dut24 (
    .clk(clk), .reset(reset), .mem_req(req24), .mem_we(we24), .mem_addr(addr24),
    .mem_wdata(wdata24), .mem_rdata(rdata24), .mem_ready(ready24), .halted(halted24), .pc(pc24)
`ifdef MULTICYCLE_CORE_HS_PERF_EN
    , .perf_cycles(perf_c24), .perf_retired(perf_r24)
`endif
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [19:0] log24[$];
  logic [15:0] model_mem [0:4095];
  int          vectors = 0;
  int          miscompares = 0;
  bit          stall_en = 0;
  bit          block_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Instruction-set interpreter: walks the program and lists the bus traffic it must cause.
  task automatic model_run(output int cycles);
    logic [15:0] r [8];
    logic [15:0] ins;
    logic [11:0] p, old;
    logic [3:0]  op;
    logic [2:0]  rn, fn;
    logic [8:0]  imm;
    logic [11:0] adr;
    bit          done;
    int          steps;
    model_mem = mem;
    foreach (r[i]) r[i] = '0;
    p = '0; cycles = 0; done = 0; steps = 0;
    while (!done && steps < 1000) begin
      ins = model_mem[p];
      exp_q.push_back('{we: 1'b0, addr: p, wdata: 16'h0});
      old = p; p = p + 12'd1; steps++;
      op = ins[15:12]; rn = ins[11:9]; imm = ins[8:0]; adr = ins[11:0]; fn = ins[2:0];
      case (op)
        4'h0: begin
          exp_q.push_back('{we: 1'b0, addr: adr, wdata: 16'h0});
          r[0] = model_mem[adr]; cycles += 4;
        end
        4'h1: begin
          exp_q.push_back('{we: 1'b1, addr: adr, wdata: r[0]});
          model_mem[adr] = r[0]; cycles += 3;
        end
        4'h2: begin p = adr; cycles += 2; end
        4'h4: begin if (r[0] == 16'h0) p = {old[11:9], imm}; cycles += 2; end
        4'h8: begin
          cycles += (fn == 3'd7) ? 3 : 4;
          case (fn)
            3'd0: r[rn] = r[0];
            3'd1: r[0] = r[rn];
            3'd2: r[0] = r[0] + r[rn];
            3'd3: r[0] = r[0] - r[rn];
            3'd4: r[0] = r[0] & r[rn];
            3'd5: r[0] = r[0] | r[rn];
            3'd6: r[0] = ~r[0];
            default: ;
          endcase
        end
        4'hC: begin r[0] = r[0] + 16'($signed(imm)); cycles += 4; end
        4'hD: begin r[0] = r[0] & {7'b0, imm}; cycles += 4; end
        4'hF: begin done = 1; cycles += 2; end
        default: cycles += 2;
      endcase
    end
  endtask

  // Memory responder: 0-3 wait cycles per request when stalling is enabled.
  initial begin : ready_drv
    bit pending = 0;
    int wl = 0;
    mem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (block_writes && mem_req && mem_we) mem_ready = 1'b0;
      else if (!stall_en) mem_ready = 1'b1;
      else if (!mem_req) begin pending = 0; mem_ready = 1'b0; end
      else begin
        if (!pending) begin pending = 1; wl = $urandom_range(0, 3); end
        if (wl == 0) begin mem_ready = 1'b1; pending = 0; end
        else begin mem_ready = 1'b0; wl--; end
      end
    end
  end

  initial begin : monitor
    bit   stalled = 0;
    txn_t held, e;
    forever begin
      @(negedge clk);
      if (reset) stalled = 0;
      else begin
        if (stalled && mem_req) begin
          check("hold_addr", mem_addr, held.addr);
          check("hold_we", mem_we, held.we);
          check("hold_wdata", mem_wdata, held.wdata);
        end
        if (mem_req && mem_ready) begin
          if (exp_q.size() == 0) check("txn_expected", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check("txn_we_addr", {mem_we, mem_addr}, {e.we, e.addr});
            if (e.we) check("txn_wdata", mem_wdata, e.wdata);
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          stalled = 0;
        end else if (mem_req) begin
          stalled = 1;
          held = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        end else stalled = 0;
      end
    end
  end

  initial begin : monitor24
    forever begin
      @(negedge clk);
      if (reset) log24.delete();
      else if (req24 && ready24 && !we24) log24.push_back(addr24);
    end
  end

  task automatic begin_test();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    foreach (mem[i]) mem[i] = '0;
  endtask

  task automatic release_and_run(input int budget, output int hc);
    hc = -1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 0);
    check("first_r0", mem_wdata, 0);
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #3;
      if (halted) begin hc = n; break; end
    end
    if (hc < 0) check("halt_reached", halted, 1);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic go(input int budget, output int hc, output int mc);
    model_run(mc);
    release_and_run(budget, hc);
  endtask

  task automatic load_basic();
    mem[0] = 16'h0100; mem[1] = 16'hC003; mem[2] = 16'h1101; mem[3] = 16'hF000;
    mem[12'h100] = 16'h0005;
  endtask

  task automatic gen_random(input int n);
    logic [3:0] nops [8] = '{4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE};
    for (int i = 0; i < n; i++) begin
      int sel;
      int tgt;
      sel = $urandom_range(0, 9);
      tgt = i + 1 + $urandom_range(0, 2);
      case (sel)
        0:       mem[i] = {4'h0, 8'h10, 4'($urandom)};
        1:       mem[i] = {4'h1, 8'h10, 4'($urandom)};
        2:       mem[i] = {4'hC, 3'b0, 9'($urandom)};
        3:       mem[i] = {4'hD, 3'b0, 9'($urandom)};
        4, 5, 6: mem[i] = {4'h8, 3'($urandom), 6'b0, 3'($urandom)};
        7:       mem[i] = {4'h4, 3'b0, 9'(tgt)};
        8:       mem[i] = {nops[$urandom_range(0, 7)], 12'($urandom)};
        default: mem[i] = {4'h2, 12'(tgt)};
      endcase
    end
    for (int i = n; i < n + 3; i++) mem[i] = 16'hF000;
    for (int i = 0; i < 16; i++) mem[256 + i] = 16'($urandom);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int hc, mc, n;

    // Reset state while held in reset.
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);

    // Basic program, zero-wait memory, plus the 24-bit JUMP wrap running alongside.
    stall_en = 0;
    begin_test();
    load_basic();
    go(100, hc, mc);
    check("t1_mem101", mem[12'h101], 16'h0008);
    check("t1_halt_cycle", hc, 13);
    check("t1_model_cycles", hc, mc);
    check("w24_fetch_count", log24.size(), 2);
    if (log24.size() >= 2) begin
      check("w24_fetch0", log24[0], 20'h00000);
      check("w24_fetch1", log24[1], 20'hFFFFF);
    end
    check("w24_pc_wrap", pc24, 20'h00000);
    check("w24_halted", halted24, 1);
`ifdef MULTICYCLE_CORE_HS_PERF_EN
    check("perf_cycles", perf_c16, 13);
    check("perf_retired", perf_r16, 3);
    repeat (3) @(posedge clk);
    #3;
    check("perf_frozen", perf_c16, 13);
    check("perf24_cycles", perf_c24, 4);
    check("perf24_retired", perf_r24, 1);
`endif

    // Same program under random 0-3 cycle stalls.
    stall_en = 1;
    for (int k = 0; k < 4; k++) begin
      begin_test();
      load_basic();
      go(400, hc, mc);
      check("t2_mem101", mem[12'h101], 16'h0008);
    end

    // BRZ taken (R0 = 0) and not taken (R0 = 1) at PC 0x205.
    stall_en = 0;
    begin_test();
    mem[0] = 16'h2205; mem[12'h205] = 16'h41F2; mem[12'h206] = 16'hF000; mem[12'h3F2] = 16'hF000;
    go(100, hc, mc);
    check("brz_taken_pc", pc, 12'h3F3);
    begin_test();
    mem[0] = 16'hC001; mem[1] = 16'h2205;
    mem[12'h205] = 16'h41F2; mem[12'h206] = 16'hF000; mem[12'h3F2] = 16'hF000;
    go(100, hc, mc);
    check("brz_nottaken_pc", pc, 12'h207);

    // CTYPE arithmetic corner cases.
    begin_test();
    mem[0] = 16'h0100; mem[1] = 16'h8600; mem[2] = 16'h8602; mem[3] = 16'h1101;
    mem[4] = 16'hD000; mem[5] = 16'h8603; mem[6] = 16'h1102; mem[7] = 16'h8006;
    mem[8] = 16'h1103; mem[9] = 16'hF000; mem[12'h100] = 16'h7FFF;
    go(200, hc, mc);
    check("ct_add", mem[12'h101], 16'hFFFE);
    check("ct_sub", mem[12'h102], 16'h8001);
    check("ct_not", mem[12'h103], 16'h7FFE);

    // Reset while a STORE is stalled in MEMWR.
    begin_test();
    mem[0] = 16'hC005; mem[1] = 16'h8600; mem[2] = 16'h1101; mem[3] = 16'hF000;
    mem[12'h101] = 16'hDEAD;
    block_writes = 1;
    model_run(mc);
    @(posedge clk); #2;
    reset = 1'b0;
    n = 0;
    while (n < 30 && !(mem_req && mem_we)) begin @(posedge clk); #2; n++; end
    check("memwr_reached", mem_req & mem_we, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_req_drop", mem_req, 0);
    block_writes = 0;
    repeat (2) @(negedge clk);
    check("rst_no_write", mem[12'h101], 16'hDEAD);
    exp_q.delete();
    mem[0] = 16'h8601; mem[1] = 16'h1102; mem[2] = 16'hF000; mem[3] = 16'h0000;
    mem[12'h102] = 16'hBEEF;
    go(100, hc, mc);
    check("rst_regs_zero", mem[12'h102], 16'h0000);

    // Random straight-line programs, alternating zero-wait and stalled memory.
    for (int t = 0; t < 12; t++) begin
      stall_en = (t % 2) == 1;
      begin_test();
      gen_random(40);
      go(2000, hc, mc);
      for (int i = 0; i < 16; i++) check("rand_mem", mem[256 + i], model_mem[256 + i]);
      if (!stall_en) check("rand_latency", hc, mc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_core_hs.md
Name: multicycle_core_hs

Overview:
- Parametrised multicycle accumulator core: datapath plus integrated control FSM in one block.
- R0 is the accumulator; there are 8 general registers R0..R7.
- Talks to a single unified instruction/data memory over a req/ready handshake, so it tolerates variable memory latency.
- Adds a HALT instruction and generalises the data width.

Parameters:
- DATA_W, 16, word and instruction width; legal values 16..32. Localparams: ADDR_W = DATA_W-4, IMM_W = DATA_W-7.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  write data, always R0.
- mem_rdata  in  DATA_W  read data; sampled only in a cycle where mem_req && mem_ready.
- mem_ready  in  1  completes the current request in the same cycle.
- halted  out  1  core is in HALT state.
- pc  out  ADDR_W  current PC, for debug.

Behaviour:
- Instruction fields:
  - op = instr[DATA_W-1 -: 4]
  - rn = instr[DATA_W-5 -: 3]
  - imm = instr[IMM_W-1:0]
  - adr = instr[ADDR_W-1:0]
  - fn = instr[2:0]
- Opcodes:
  - 0000 LOAD: R0 <- M[adr].
  - 0001 STORE: M[adr] <- R0.
  - 0010 JUMP: PC <- adr.
  - 0100 BRZ: if R0 == 0, PC <- {OldPC[ADDR_W-1:IMM_W], imm}.
  - 1000 CTYPE, selected by fn:
    - 000 Rn <- R0
    - 001 R0 <- Rn
    - 010 R0 <- R0+Rn
    - 011 R0 <- R0-Rn
    - 100 R0 <- R0&Rn
    - 101 R0 <- R0|Rn
    - 110 R0 <- ~R0
    - 111 NOP
  - 1100 ADDI: R0 <- R0 + sign-extended imm.
  - 1101 ANDI: R0 <- R0 & zero-extended imm.
  - 1111 HALT.
  - Any other opcode executes as a NOP.
- Arithmetic is modulo 2^DATA_W. No flags are stored; the BRZ test uses R0 as read in DECODE.
- FSM states: FETCH, DECODE, MEMRD, MEMWR, EXEC, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR <- rdata, OldPC <- PC, PC <- PC+1 (wraps at 2^ADDR_W), go to DECODE. Otherwise hold all outputs stable.
  - DECODE: registers A <- R0, B <- R[rn].
    - JUMP and BRZ update PC here and return to FETCH.
    - LOAD goes to MEMRD; STORE goes to MEMWR.
    - CTYPE, ADDI and ANDI go to EXEC.
    - HALT goes to HALT.
    - NOP returns to FETCH.
  - MEMRD: mem_req=1, mem_we=0, mem_addr=adr. On ready: MDR <- rdata, go to WB.
  - MEMWR: mem_req=1, mem_we=1, mem_addr=adr, mem_wdata=R0. On ready, go to FETCH.
  - EXEC: ALUOut <- result, go to WB. CTYPE NOP skips WB and goes straight to FETCH.
  - WB: write R0 (or Rn for fn=000) from ALUOut, or from MDR for LOAD; go to FETCH.
  - HALT: absorbing state; halted=1, mem_req=0. Only reset exits.
- Zero-wait latency (mem_ready tied high): JUMP/BRZ/NOP 2 cycles, STORE 3, LOAD/ALU 4. Each wait cycle adds exactly one cycle.
- The request must be held: mem_addr, mem_we and mem_wdata must not change while mem_req=1 and mem_ready=0. mem_req=0 in DECODE, EXEC, WB and HALT.
- Register file updates only in WB. Writes are visible to the next DECODE; no bypass is needed.
- Reset mid-operation (including mid-handshake): all of the following apply immediately, and mem_req drops asynchronously:
  - state = FETCH, PC = RESET_PC
  - IR, OldPC, MDR, A, B, ALUOut and all registers = 0
  - halted = 0, mem_req = 0
  - The first request is asserted in the first cycle after reset deasserts.

Optional Feature:
- Macro MULTICYCLE_CORE_HS_PERF_EN.
- When defined, adds two 32-bit outputs, both reset to 0, both wrapping at 2^32, and both frozen while halted:
  - perf_cycles: increments every non-HALT cycle.
  - perf_retired: increments on each transition into FETCH from any other state.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- DATA_W=16, mem_ready=1. Program: LOAD 0x100 (M=0x0005), ADDI 3, STORE 0x101, HALT. Required: M[0x101]=0x0008; halted=1 at cycle 13 after reset release.
- Random 0-3 cycle mem_ready stalls on the same program. Required: identical memory result, and mem_addr/mem_we/mem_wdata stable throughout every stall.
- R0=0, BRZ with imm=0x1F2 at PC 0x205. Required: PC=0x3F2. Repeat with R0=1: required PC=0x206.
- CTYPE sequence R0=0x7FFF, MOVTO R3, ADD R3. Required: R0=0xFFFE. Then SUB R3 from 0x0000 gives R0=0x8001; NOT then gives 0x7FFE.
- Assert reset while in MEMWR with mem_ready=0. Required: mem_req=0 the same cycle, no write occurs, and the next request is a fetch at RESET_PC with all registers at 0.
- DATA_W=24, JUMP 0xFFFFF followed by instruction fetch. Required: fetch addr=0xFFFFF, then PC wraps to 0x00000.
